// File: rtl/ex_trap_arbiter_if.sv
// Bundle between interrupt sources, the external-trap arbiter and the core's trap port.
// slave = arbiter side, master = the environment (sources plus core) that drives it.
interface ex_trap_arbiter_if #(
  parameter int NREQ = 4
);
  localparam int SW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Sources hold req_valid_i as a level. The arbiter answers the granted source with a
  // one-cycle req_ready_o pulse. Toward the core, core_ex_trap_valid_o stays high until
  // the core raises core_ex_trap_ready_i (transfer on a clock edge where both are high)
  // or until the timeout abort. Valid never drops before one of those two events.
  logic [NREQ-1:0] req_valid_i;
  logic [NREQ-1:0] req_mask_i;
  logic [NREQ-1:0] req_ready_o;
  logic            core_ex_trap_valid_o;
  logic            core_ex_trap_ready_i;
  logic [SW-1:0]   trap_src_o;
  logic            busy_o;
  logic            timeout_o;
  logic [1:0]      fsm_state;

  modport slave (
    input  req_valid_i, req_mask_i, core_ex_trap_ready_i,
    output req_ready_o, core_ex_trap_valid_o, trap_src_o, busy_o, timeout_o, fsm_state
  );

  modport master (
    output req_valid_i, req_mask_i, core_ex_trap_ready_i,
    input  req_ready_o, core_ex_trap_valid_o, trap_src_o, busy_o, timeout_o, fsm_state
  );
endinterface

// File: rtl/ex_trap_arbiter.sv
// Round-robin arbiter sharing the core's single external-trap handshake among NREQ
// masked interrupt sources, with a committed grant, ack pulse and timeout abort.
module ex_trap_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  ex_trap_arbiter_if.slave bus
);
  localparam int SW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_COOL  = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [SW-1:0]   rr_ptr, rr_ptr_n;
  logic [SW-1:0]   gnt, gnt_n;
  logic [SW-1:0]   src, src_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic            valid, valid_n;
  logic            tmo, tmo_n;
  logic [NREQ-1:0] ack, ack_n;

  logic [NREQ-1:0] elig;
  logic [SW-1:0]   pick;
  logic            found;

  assign elig = bus.req_valid_i & bus.req_mask_i;

  function automatic logic [SW-1:0] wrap_inc(input logic [SW-1:0] v);
    if (int'(v) == NREQ - 1) return '0;
    return v + 1'b1;
  endfunction

  // First eligible source at or above rr_ptr, wrapping modulo NREQ (NREQ need not be 2^n).
  always_comb begin
    int            idx;
    logic [SW-1:0] idx_s;
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    idx_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      idx_s = SW'(idx);
      if (!found && elig[idx_s]) begin
        found = 1'b1;
        pick  = idx_s;
      end
    end
  end

  always_comb begin
    state_n  = state;
    rr_ptr_n = rr_ptr;
    gnt_n    = gnt;
    src_n    = src;
    cnt_n    = cnt;
    valid_n  = valid;
    tmo_n    = 1'b0;
    ack_n    = '0;
    case (state)
      ST_IDLE: begin
        cnt_n = '0;
        if (found) begin
          gnt_n   = pick;
          src_n   = pick;
          valid_n = 1'b1;
          state_n = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // The grant is committed: the winner's req/mask are not looked at again here.
        cnt_n = cnt + 1'b1;
        if (bus.core_ex_trap_ready_i) begin
          valid_n    = 1'b0;
          ack_n[gnt] = 1'b1;
          rr_ptr_n   = wrap_inc(gnt);
          state_n    = ST_COOL;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          valid_n  = 1'b0;
          tmo_n    = 1'b1;
          rr_ptr_n = wrap_inc(gnt);
          state_n  = ST_COOL;
        end
      end
      ST_COOL: begin
        // One dead cycle so valid is low for at least two cycles between requests.
        state_n = ST_IDLE;
      end
      default: begin
        valid_n = 1'b0;
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      rr_ptr <= '0;
      gnt    <= '0;
      src    <= '0;
      cnt    <= '0;
      valid  <= 1'b0;
      tmo    <= 1'b0;
      ack    <= '0;
    end else begin
      state  <= state_n;
      rr_ptr <= rr_ptr_n;
      gnt    <= gnt_n;
      src    <= src_n;
      cnt    <= cnt_n;
      valid  <= valid_n;
      tmo    <= tmo_n;
      ack    <= ack_n;
    end
  end

  assign bus.req_ready_o          = ack;
  assign bus.core_ex_trap_valid_o = valid;
  assign bus.trap_src_o           = src;
  assign bus.timeout_o            = tmo;
  assign bus.busy_o               = (state != ST_IDLE);
  assign bus.fsm_state            = state;
endmodule

// File: tb/tb_ex_trap_arbiter.sv
// Directed bench for ex_trap_arbiter (NREQ=4, TIMEOUT=16): reset, single, fairness,
// mask, timeout, ready-on-last-cycle and mid-transfer reset.
module tb_ex_trap_arbiter;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 16;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  logic [31:0] exp_q[$];

  ex_trap_arbiter_if #(.NREQ(NREQ)) bus ();

  ex_trap_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, observed=running expected=done");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Serves one trap: waits for valid, checks the source against the scoreboard, raises
  // ready when valid has been high for delay+1 cycles (delay<0: never), checks the
  // ack/timeout outcome, and returns one cycle later with outputs back to quiet.
  task automatic serve(input int delay);
    int          n;
    int          hi;
    logic [31:0] exp_src;
    exp_src = '0;
    if (exp_q.size() > 0) exp_src = exp_q.pop_front();
    n = 0;
    while (!bus.core_ex_trap_valid_o && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk("valid_rise", 32'(bus.core_ex_trap_valid_o), 32'd1);
    chk("trap_src", 32'(bus.trap_src_o), exp_src);
    chk("busy", 32'(bus.busy_o), 32'd1);
    hi = 0;
    while (bus.core_ex_trap_valid_o && hi < 100) begin
      bus.core_ex_trap_ready_i = (hi == delay);
      hi++;
      @(negedge clk);
    end
    bus.core_ex_trap_ready_i = 1'b0;
    if (delay < 0) begin
      chk("valid_len_tmo", 32'(hi), 32'(TIMEOUT));
      chk("timeout_pulse", 32'(bus.timeout_o), 32'd1);
      chk("no_ack_tmo", 32'(bus.req_ready_o), 32'd0);
    end else begin
      chk("valid_len", 32'(hi), 32'(delay + 1));
      chk("ack", 32'(bus.req_ready_o), 32'd1 << exp_src);
      chk("no_timeout", 32'(bus.timeout_o), 32'd0);
    end
    @(negedge clk);
    chk("ack_one_cycle", 32'(bus.req_ready_o), 32'd0);
    chk("timeout_one_cycle", 32'(bus.timeout_o), 32'd0);
    chk("valid_low_gap", 32'(bus.core_ex_trap_valid_o), 32'd0);
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_valid"}, 32'(bus.core_ex_trap_valid_o), 32'd0);
    chk({tag, "_ack"}, 32'(bus.req_ready_o), 32'd0);
    chk({tag, "_src"}, 32'(bus.trap_src_o), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy_o), 32'd0);
    chk({tag, "_timeout"}, 32'(bus.timeout_o), 32'd0);
    chk({tag, "_state"}, 32'(bus.fsm_state), 32'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.req_valid_i          = 4'hF;
    bus.req_mask_i           = 4'hF;
    bus.core_ex_trap_ready_i = 1'b0;

    // 1: reset with every source requesting, then first grant goes to source 0
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_quiet("reset");
    rst = 1'b0;
    exp_q.push_back(32'd0);
    serve(1);

    // 2: single requester, core ready 3 cycles after valid rises
    bus.req_valid_i = 4'b0100;
    exp_q.push_back(32'd2);
    serve(3);
    bus.req_valid_i = 4'b0000;
    @(negedge clk);
    chk("idle_no_req", 32'(bus.busy_o), 32'd0);

    // 3: fairness from a fresh pointer, all sources held
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.req_valid_i = 4'hF;
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd1);
    exp_q.push_back(32'd2);
    exp_q.push_back(32'd3);
    exp_q.push_back(32'd0);
    for (int i = 0; i < 5; i++) serve(1);

    // 4: sources 0 and 2 masked, pointer is at 1
    bus.req_mask_i = 4'b1010;
    exp_q.push_back(32'd1);
    exp_q.push_back(32'd3);
    exp_q.push_back(32'd1);
    for (int i = 0; i < 3; i++) serve(0);

    // 5: timeout on source 1 with ready tied low; pointer then moves to 2
    bus.req_mask_i  = 4'hF;
    bus.req_valid_i = 4'b0010;
    exp_q.push_back(32'd1);
    serve(-1);
    bus.req_valid_i = 4'hF;

    // 6a: ready on the last cycle before timeout wins
    exp_q.push_back(32'd2);
    serve(TIMEOUT - 1);

    // 6b: reset in the middle of an ISSUE toward source 3, then pointer is back at 0
    begin
      int n;
      n = 0;
      while (!bus.core_ex_trap_valid_o && n < 64) begin
        @(negedge clk);
        n++;
      end
    end
    chk("pre_rst_src", 32'(bus.trap_src_o), 32'd3);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_quiet("mid_rst");
    rst = 1'b0;
    exp_q.push_back(32'd0);
    serve(2);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
